sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 136 +++++++++++++
 tb/tb_sysid_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: reads ID (word 0) and build timestamp (word 1) over Avalon-MM, compares them to EXPECTED_ID/EXPECTED_TS; ports: clock/reset, start pulse, av_* read master, captured id_value/ts_value, status busy/done/pass/id_match/ts_match/timeout
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h547C_CFC3,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, REQ, LAT, CAPT, DONE} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);
  state_t state_q, state_d;
  logic idx_q, idx_d;
  logic [1:0] lat_q, lat_d;
  logic [15:0] to_q, to_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic id_match_q, id_match_d, ts_match_q, ts_match_d;
  logic timeout_q, timeout_d, pass_q, pass_d;
  logic av_read_q, av_read_d, busy_q, busy_d, done_q, done_d;
  logic capture;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    lat_d = lat_q;
    to_d = to_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d = timeout_q;
    pass_d = pass_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = REQ;
        idx_d = 1'b0;
        to_d = '0;
        id_match_d = 1'b0;
        ts_match_d = 1'b0;
        timeout_d = 1'b0;
        pass_d = 1'b0;
      end
      REQ: if (av_waitrequest) begin
        if (to_q == TO_LAST) begin
          state_d = DONE;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 16'd1;
        end
      end else begin
        to_d = '0;
        if (READ_LATENCY == 0) begin
          capture = 1'b1;
          state_d = CAPT;
        end else begin
          lat_d = LAT_LOAD;
          state_d = LAT;
        end
      end
      LAT: if (lat_q == 2'd0) begin
        capture = 1'b1;
        state_d = CAPT;
      end else begin
        lat_d = lat_q - 2'd1;
      end
      CAPT: if (idx_q) begin
        ts_match_d = ts_value_q == EXPECTED_TS;
        pass_d = id_match_q && ts_value_q == EXPECTED_TS;
        state_d = DONE;
      end else begin
        id_match_d = id_value_q == EXPECTED_ID;
        idx_d = 1'b1;
        state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    id_value_d = capture && !idx_q ? av_readdata : id_value_q;
    ts_value_d = capture && idx_q ? av_readdata : ts_value_q;
    av_read_d = state_d == REQ;
    busy_d = state_d == REQ || state_d == LAT || state_d == CAPT;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 1'b0;
      lat_q <= '0;
      to_q <= '0;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q <= 1'b0;
      pass_q <= 1'b0;
      av_read_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      lat_q <= lat_d;
      to_q <= to_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q <= timeout_d;
      pass_q <= pass_d;
      av_read_q <= av_read_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign av_address = idx_q;
  assign av_read = av_read_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign id_match = id_match_q;
  assign ts_match = ts_match_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench for a zero-latency/stallable slave (dut_a) and a latency-2 slave (dut_b)
`timescale 1ns/1ps
module tb_sysid_checker;
  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ts;
    logic idm, tsm, to, pass;
  } res_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  int tests = 0, fails = 0;
  res_t exp_a[$], exp_b[$];
  logic rst_a, start_a, addr_a, read_a, wait_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
  logic [31:0] rdata_a, id_a, ts_a;
  logic [31:0] mem_a [2];
  int stall_a = 0, cnt_a = 0;
  logic stuck_a = 1'b0;
  logic acc_a[$];
  logic rst_b, start_b, addr_b, read_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
  logic [31:0] rdata_b, id_b, ts_b;
  logic [31:0] mem_b [2];
  logic v1 = 1'b0, v2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;
  sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .av_address(addr_a), .av_read(read_a),
    .av_waitrequest(wait_a), .av_readdata(rdata_a), .id_value(id_a), .ts_value(ts_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .id_match(idm_a), .ts_match(tsm_a), .timeout(to_a)
  );
  sysid_checker #(.EXPECTED_ID(32'h1234_5678), .READ_LATENCY(2)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .av_address(addr_b), .av_read(read_b),
    .av_waitrequest(1'b0), .av_readdata(rdata_b), .id_value(id_b), .ts_value(ts_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .id_match(idm_b), .ts_match(tsm_b), .timeout(to_b)
  );
  assign wait_a = stuck_a || (read_a && cnt_a < stall_a);
  assign rdata_a = mem_a[addr_a];
  always @(posedge clock)
    if (read_a && !wait_a) begin
      cnt_a <= 0;
      acc_a.push_back(addr_a);
    end else if (read_a) begin
      cnt_a <= cnt_a + 1;
    end
  always @(posedge clock) begin
    v1 <= read_b;
    d1 <= mem_b[addr_b];
    v2 <= v1;
    d2 <= d1;
  end
  assign rdata_b = v2 ? d2 : 32'hDEAD_BEEF;
  function automatic res_t mk(logic [31:0] id, logic [31:0] ts, logic idm, logic tsm, logic to, logic pass);
    mk = '{id, ts, idm, tsm, to, pass};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  task automatic cmp_res(string t, res_t e, res_t a);
    chk({t, "_id_value"}, a.id, e.id);
    chk({t, "_ts_value"}, a.ts, e.ts);
    chk({t, "_flags(idm,tsm,to,pass)"}, 32'({a.idm, a.tsm, a.to, a.pass}), 32'({e.idm, e.tsm, e.to, e.pass}));
  endtask
  logic dprev_a = 1'b0, dprev_b = 1'b0, pstall_a = 1'b0, paddr_a = 1'b0;
  always @(negedge clock) begin
    if (done_a && !dprev_a) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_a: done rose with no expected result queued");
      end else cmp_res("sb_a", exp_a.pop_front(), mk(id_a, ts_a, idm_a, tsm_a, to_a, pass_a));
    end
    if (done_b && !dprev_b) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_b: done rose with no expected result queued");
      end else cmp_res("sb_b", exp_b.pop_front(), mk(id_b, ts_b, idm_b, tsm_b, to_b, pass_b));
    end
    if (pstall_a && !stuck_a) begin
      chk("stall_read_hold", 32'(read_a), 32'd1);
      chk("stall_addr_hold", 32'(addr_a), 32'(paddr_a));
    end
    dprev_a <= done_a;
    dprev_b <= done_b;
    pstall_a <= read_a && wait_a;
    paddr_a <= addr_a;
  end
  task automatic go_a;
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
  endtask
  task automatic go_b;
    @(posedge clock); #1 start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
  endtask
  task automatic wait_done(input logic sel_b, input int maxc, output int n);
    n = 0;
    while (!(sel_b ? done_b : done_a) && n < maxc) begin
      @(posedge clock); #1;
      n++;
    end
    chk(sel_b ? "wait_done_b" : "wait_done_a", 32'(sel_b ? done_b : done_a), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mem_a[0] = 32'h0; mem_a[1] = 32'h547C_CFC3;
    mem_b[0] = 32'h1234_5678; mem_b[1] = 32'h547C_CFC3;
    #12;
    chk("rst_a_flags", 32'({addr_a, read_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a}), 32'd0);
    chk("rst_a_values", id_a | ts_a, 32'd0);
    chk("rst_b_flags", 32'({addr_b, read_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b}), 32'd0);
    @(negedge clock) begin rst_a = 1'b0; rst_b = 1'b0; end
    repeat (3) @(posedge clock);
    #1 chk("idle_hold_a", 32'({busy_a, done_a, read_a}), 32'd0);
    // nominal zero-wait run: done/pass on the 5th edge counting the start edge
    acc_a.delete();
    exp_a.push_back(mk(32'h0, 32'h547C_CFC3, 1'b1, 1'b1, 1'b0, 1'b1));
    go_a;
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_read", 32'(read_a), 32'd1);
    repeat (3) @(posedge clock);
    #1 chk("t1_done_early", 32'(done_a), 32'd0);
    @(posedge clock);
    #1 chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_busy_off", 32'(busy_a), 32'd0);
    chk("t1_nreads", 32'(acc_a.size()), 32'd2);
    if (acc_a.size() == 2) chk("t1_addr_seq", 32'({acc_a[0], acc_a[1]}), 32'b01);
    // timestamp off by one; restart from DONE; start while busy is ignored
    mem_a[1] = 32'h547C_CFC2;
    exp_a.push_back(mk(32'h0, 32'h547C_CFC2, 1'b1, 1'b0, 1'b0, 1'b0));
    go_a;
    chk("t2_done_cleared", 32'(done_a), 32'd0);
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    @(posedge clock);
    #1 chk("t2_done_early", 32'(done_a), 32'd0);
    @(posedge clock);
    #1 chk("t2_done", 32'(done_a), 32'd1);
    // 3 stall cycles per read
    mem_a[1] = 32'h547C_CFC3;
    stall_a = 3;
    exp_a.push_back(mk(32'h0, 32'h547C_CFC3, 1'b1, 1'b1, 1'b0, 1'b1));
    go_a;
    wait_done(1'b0, 30, n);
    chk("t3_cycles", 32'(n), 32'd10);
    stall_a = 0;
    // ID mismatch in the MSB only
    mem_a[0] = 32'h8000_0000;
    exp_a.push_back(mk(32'h8000_0000, 32'h547C_CFC3, 1'b0, 1'b1, 1'b0, 1'b0));
    go_a;
    wait_done(1'b0, 20, n);
    mem_a[0] = 32'h0;
    // stuck slave: after a fresh reset, av_read must drop after 4 stall cycles
    @(negedge clock) rst_a = 1'b1;
    @(negedge clock) rst_a = 1'b0;
    stuck_a = 1'b1;
    exp_a.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    go_a;
    n = 0;
    repeat (10) begin
      n += int'(read_a);
      @(posedge clock); #1;
    end
    chk("t4_read_cycles", 32'(n), 32'd4);
    chk("t4_done_timeout", 32'({done_a, to_a, pass_a}), 32'b110);
    stuck_a = 1'b0;
    // latency-2 slave: garbage is presented one cycle before the real data
    exp_b.push_back(mk(32'h1234_5678, 32'h547C_CFC3, 1'b1, 1'b1, 1'b0, 1'b1));
    go_b;
    wait_done(1'b1, 20, n);
    chk("t5_cycles", 32'(n), 32'd8);
    // reset while waiting out the second read's latency
    go_b;
    n = 0;
    while (!(read_b && addr_b) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t6_second_read_seen", 32'(read_b && addr_b), 32'd1);
    @(posedge clock);
    #2 rst_b = 1'b1;
    #1 chk("t6_rst_flags", 32'({addr_b, read_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b}), 32'd0);
    chk("t6_rst_id", id_b, 32'd0);
    chk("t6_rst_ts", ts_b, 32'd0);
    @(negedge clock) rst_b = 1'b0;
    exp_b.push_back(mk(32'h1234_5678, 32'h547C_CFC3, 1'b1, 1'b1, 1'b0, 1'b1));
    go_b;
    wait_done(1'b1, 20, n);
    repeat (3) @(posedge clock);
    #1 chk("sb_a_drain", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drain", 32'(exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
